// File: rtl/fp_int_mac_seq.sv
// Dot-product sequencer: buffers FP16/INT4 pairs, then drives one external fp_int_mac
// element by element, chaining the accumulator, and returns the result on a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for the first element of a vector
// LOAD   | buffering elements, tracking minimum exponent
// ISSUE  | one-cycle mac_start for element idx
// WAIT   | operands held, waiting for mac_done or timeout
// DONE   | result presented until res_ready
module fp_int_mac_seq #(
    parameter int ACT_WIDTH = 16,
    parameter int W_WIDTH   = 4,
    parameter int ACC_WIDTH = 32,
    parameter int DEPTH     = 16,
    parameter int TIMEOUT   = 255,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [W_WIDTH-1:0]   in_weight,
    input  logic                 in_last,
    input  logic [ACC_WIDTH-1:0] acc_init,
    output logic                 mac_start,
    output logic [ACT_WIDTH-1:0] mac_activation,
    output logic [W_WIDTH-1:0]   mac_weight,
    output logic [4:0]           mac_exp_min,
    output logic [ACC_WIDTH-1:0] mac_acc,
    input  logic [ACC_WIDTH-1:0] mac_acc_out,
    input  logic [4:0]           mac_exp_out,
    input  logic                 mac_done,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_WIDTH-1:0] res_acc,
    output logic [4:0]           res_exp,
    output logic [CNT_W-1:0]     res_count,
    output logic                 res_err,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ACT_WIDTH-1:0] act_buf [DEPTH];
    logic [W_WIDTH-1:0]   w_buf   [DEPTH];

    logic [CNT_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     idx;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [ACC_WIDTH-1:0] running_acc;
    logic [4:0]           exp_min;
    logic [4:0]           res_exp_q;
    logic                 err_q;
    logic                 armed;

    logic       accept;
    logic       load_end;
    logic       tmo_hit;
    logic       more_ops;
    logic       op_en;
    logic [4:0] in_exp;

    assign in_exp   = in_act[14:10];
    assign accept   = in_valid && in_ready;
    assign load_end = in_last || (wr_ptr == CNT_W'(DEPTH - 1));
    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT));
    assign more_ops = ((idx + CNT_W'(1)) < count);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = in_last ? S_ISSUE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept && load_end) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                // a done arriving on the expiry cycle still wins over the timeout
                if (mac_done) begin
                    state_nxt = more_ops ? S_ISSUE : S_DONE;
                end else if (tmo_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        op_en          = (state == S_ISSUE) || (state == S_WAIT);
        in_ready       = armed && ((state == S_IDLE) || (state == S_LOAD));
        mac_start      = (state == S_ISSUE);
        mac_activation = op_en ? act_buf[idx[IDX_W-1:0]] : '0;
        mac_weight     = op_en ? w_buf[idx[IDX_W-1:0]] : '0;
        mac_exp_min    = op_en ? exp_min : '0;
        mac_acc        = op_en ? running_acc : '0;
        res_valid      = (state == S_DONE);
        res_acc        = res_valid ? running_acc : '0;
        res_exp        = res_valid ? res_exp_q : '0;
        res_count      = res_valid ? count : '0;
        res_err        = res_valid ? err_q : 1'b0;
        busy           = (state != S_IDLE);
    end

    // element storage carries no reset; its contents are meaningless outside a job
    always_ff @(posedge clk) begin
        if (accept) begin
            act_buf[wr_ptr[IDX_W-1:0]] <= in_act;
            w_buf[wr_ptr[IDX_W-1:0]]   <= in_weight;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            count       <= '0;
            idx         <= '0;
            tmo_cnt     <= '0;
            running_acc <= '0;
            exp_min     <= '0;
            res_exp_q   <= '0;
            err_q       <= 1'b0;
            armed       <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        running_acc <= acc_init;
                        exp_min     <= in_exp;
                        res_exp_q   <= '0;
                        wr_ptr      <= CNT_W'(1);
                        if (in_last) begin
                            count <= CNT_W'(1);
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + CNT_W'(1);
                        if (in_exp < exp_min) begin
                            exp_min <= in_exp;
                        end
                        if (load_end) begin
                            count <= wr_ptr + CNT_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                end
                S_WAIT: begin
                    if (mac_done) begin
                        running_acc <= mac_acc_out;
                        res_exp_q   <= mac_exp_out;
                        idx         <= idx + CNT_W'(1);
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        wr_ptr  <= '0;
                        count   <= '0;
                        idx     <= '0;
                        tmo_cnt <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_int_mac_seq.sv
// Bench for fp_int_mac_seq: behavioural MAC with configurable latency, operand and
// result scoreboards fed from the stimulus vectors.
module tb_fp_int_mac_seq;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 255;
    localparam int CNT_W   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_act;
    logic [3:0]  in_weight;
    logic [31:0] acc_init;
    logic        mac_start, mac_done;
    logic [15:0] mac_activation;
    logic [3:0]  mac_weight;
    logic [4:0]  mac_exp_min;
    logic [31:0] mac_acc, mac_acc_out;
    logic [4:0]  mac_exp_out;
    logic        res_valid, res_ready, res_err, busy;
    logic [31:0] res_acc;
    logic [4:0]  res_exp;
    logic [CNT_W-1:0] res_count;

    always #5 clk = ~clk;

    fp_int_mac_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
        .in_weight(in_weight), .in_last(in_last), .acc_init(acc_init),
        .mac_start(mac_start), .mac_activation(mac_activation),
        .mac_weight(mac_weight), .mac_exp_min(mac_exp_min), .mac_acc(mac_acc),
        .mac_acc_out(mac_acc_out), .mac_exp_out(mac_exp_out), .mac_done(mac_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_acc(res_acc),
        .res_exp(res_exp), .res_count(res_count), .res_err(res_err), .busy(busy)
    );

    typedef struct packed {
        logic [15:0] act;
        logic [3:0]  w;
        logic [4:0]  emin;
        logic [31:0] acc;
    } op_t;

    typedef struct packed {
        logic [31:0] acc;
        logic [4:0]  e;
        logic [4:0]  cnt;
        logic        err;
    } res_t;

    op_t  op_q[$];
    res_t res_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int n_starts = 0;
    int start_cyc = 0;
    int valid_cyc = 0;

    logic [15:0] jact [DEPTH];
    logic [3:0]  jw   [DEPTH];
    logic [31:0] jinit;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mac_acc_fn(logic [15:0] a, logic [3:0] w, logic [4:0] e,
                                               logic [31:0] acc);
        logic signed [31:0] prod;
        prod = $signed({22'd0, a[9:0]}) * $signed({{28{w[3]}}, w});
        return acc + $unsigned(prod) + {27'd0, e};
    endfunction

    function automatic logic [4:0] mac_exp_fn(logic [15:0] a, logic [4:0] e);
        return a[14:10] - e;
    endfunction

    // behavioural MAC: captures operands on mac_start, answers after a countdown
    logic        mac_en = 1'b1;
    logic        lat_rand = 1'b0;
    int          fixed_lat = 3;
    logic        mac_busy, mac_done_r;
    int          mac_cnt;
    op_t         m_op;
    logic        spur_idle = 1'b0;
    logic        spur_iss = 1'b0;
    logic        spur_issue_en = 1'b0;

    assign mac_done = mac_done_r | spur_idle | spur_iss;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_busy    <= 1'b0;
            mac_done_r  <= 1'b0;
            mac_cnt     <= 0;
            m_op        <= '0;
            mac_acc_out <= '0;
            mac_exp_out <= '0;
        end else begin
            mac_done_r <= 1'b0;
            if (mac_start) begin
                mac_busy <= 1'b1;
                mac_cnt  <= lat_rand ? int'($urandom_range(0, 7)) : fixed_lat;
                m_op     <= '{mac_activation, mac_weight, mac_exp_min, mac_acc};
            end else if (mac_busy && mac_en) begin
                if (mac_cnt == 0) begin
                    mac_done_r  <= 1'b1;
                    mac_busy    <= 1'b0;
                    mac_acc_out <= mac_acc_fn(m_op.act, m_op.w, m_op.emin, m_op.acc);
                    mac_exp_out <= mac_exp_fn(m_op.act, m_op.emin);
                end else begin
                    mac_cnt <= mac_cnt - 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // operand scoreboard and WAIT-phase stability monitor
    initial begin
        logic        track;
        logic        prev_start;
        logic [56:0] hold;
        op_t         o;
        track = 1'b0;
        prev_start = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk);
            spur_iss = spur_issue_en && mac_start && rst;
            if (!rst) begin
                track = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (mac_start) begin
                    n_starts++;
                    start_cyc = cyc;
                    check_val("start_pulse", 64'(prev_start), 64'(0));
                    check_val("op_expected", 64'(op_q.size() != 0), 64'(1));
                    if (op_q.size() != 0) begin
                        o = op_q.pop_front();
                        check_val("op_act", 64'(mac_activation), 64'(o.act));
                        check_val("op_weight", 64'(mac_weight), 64'(o.w));
                        check_val("op_exp_min", 64'(mac_exp_min), 64'(o.emin));
                        check_val("op_acc", 64'(mac_acc), 64'(o.acc));
                    end
                    hold = {mac_activation, mac_weight, mac_exp_min, mac_acc};
                    track = 1'b1;
                end else if (track && !res_valid) begin
                    check_val("op_stable", 64'({mac_activation, mac_weight, mac_exp_min, mac_acc}),
                              64'(hold));
                    if (mac_done_r) track = 1'b0;
                end else begin
                    track = 1'b0;
                end
                prev_start = mac_start;
            end
        end
    end

    task automatic send_elem(input logic [15:0] a, input logic [3:0] w, input logic last,
                             input logic [31:0] init);
        int n;
        n = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_act    = a;
        in_weight = w;
        in_last   = last;
        acc_init  = init;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_bound", 64'(n < 200), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        acc_init = $urandom;
    endtask

    task automatic wait_result(input int hold_cycles);
        int n;
        res_t e;
        logic [42:0] snap;
        n = 0;
        while (!res_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("res_valid_bound", 64'(n < 2000), 64'(1));
        valid_cyc = cyc;
        snap = {res_acc, res_exp, res_count, res_err};
        for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk);
            check_val("res_hold", 64'({res_valid, res_acc, res_exp, res_count, res_err}),
                      64'({1'b1, snap}));
            check_val("hold_in_ready", 64'(in_ready), 64'(0));
        end
        res_ready = 1'b1;
        check_val("res_expected", 64'(res_q.size() != 0), 64'(1));
        if (res_q.size() != 0) begin
            e = res_q.pop_front();
            check_val("res_acc", 64'(res_acc), 64'(e.acc));
            if (!e.err) check_val("res_exp", 64'(res_exp), 64'(e.e));
            check_val("res_count", 64'(res_count), 64'(e.cnt));
            check_val("res_err", 64'(res_err), 64'(e.err));
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check_val("res_valid_clear", 64'(res_valid), 64'(0));
        check_val("ready_after_done", 64'(in_ready), 64'(1));
    endtask

    // mode 0: normal, 1: MAC never answers (timeout), 2: job will be aborted by reset
    task automatic run_job(input int n, input logic use_last, input int mode, input int hold_cycles);
        logic [4:0]  emin;
        logic [31:0] acc;
        res_t        r;
        int          s0;
        emin = jact[0][14:10];
        for (int i = 1; i < n; i++) begin
            if (jact[i][14:10] < emin) emin = jact[i][14:10];
        end
        acc = jinit;
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (mode == 0 || i == 0) op_q.push_back('{jact[i], jw[i], emin, acc});
            if (mode == 0) begin
                r.e = mac_exp_fn(jact[i], emin);
                acc = mac_acc_fn(jact[i], jw[i], emin, acc);
            end
        end
        r.acc = acc;
        r.cnt = 5'(n);
        r.err = (mode == 1);
        if (mode != 2) res_q.push_back(r);
        s0 = n_starts;
        for (int i = 0; i < n; i++) begin
            send_elem(jact[i], jw[i], use_last && (i == n - 1), (i == 0) ? jinit : $urandom);
        end
        @(negedge clk);
        check_val("ready_drop", 64'(in_ready), 64'(0));
        if (mode != 2) begin
            wait_result(hold_cycles);
            check_val("start_count", 64'(n_starts - s0), 64'((mode == 0) ? n : 1));
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            jact[i] = 16'($urandom);
            jw[i]   = 4'($urandom);
        end
        jinit = $urandom;
    endtask

    initial begin
        int n;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_act    = '0;
        in_weight = '0;
        acc_init  = '0;
        res_ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_outputs", 64'(|{in_ready, mac_start, mac_activation, mac_weight, mac_exp_min,
                  mac_acc, res_valid, res_acc, res_exp, res_count, res_err, busy}), 64'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_in_ready", 64'(in_ready), 64'(1));
        check_val("idle_busy", 64'(busy), 64'(0));

        // two-element vector, fixed MAC latency
        fixed_lat = 3;
        jact[0] = 16'h4569; jw[0] = 4'b0110;
        jact[1] = 16'h4AAA; jw[1] = 4'b0101;
        jinit = 32'd2;
        run_job(2, 1'b1, 0, 0);

        // full-depth vector without in_last
        fill_random(DEPTH);
        run_job(DEPTH, 1'b0, 0, 0);

        // random lengths and latencies with spurious mac_done in IDLE and ISSUE
        lat_rand = 1'b1;
        spur_issue_en = 1'b1;
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, DEPTH);
            fill_random(n);
            @(negedge clk);
            spur_idle = 1'b1;
            @(negedge clk);
            spur_idle = 1'b0;
            run_job(n, 1'b1, 0, 0);
        end
        spur_issue_en = 1'b0;
        lat_rand = 1'b0;

        // MAC never completes
        mac_en = 1'b0;
        fill_random(3);
        run_job(3, 1'b1, 1, 0);
        check_val("tmo_latency", 64'(valid_cyc - start_cyc), 64'(TIMEOUT + 2));
        mac_en = 1'b1;
        repeat (6) @(negedge clk);

        // result back-pressure, then a follow-on job
        fill_random(4);
        run_job(4, 1'b1, 0, 10);
        fill_random(5);
        run_job(5, 1'b1, 0, 0);

        // reset in the middle of WAIT
        mac_en = 1'b0;
        fill_random(3);
        run_job(3, 1'b1, 2, 0);
        repeat (3) @(negedge clk);
        check_val("abort_in_wait", 64'({busy, res_valid, mac_start}), 64'(3'b100));
        #2 rst = 1'b0;
        #1;
        check_val("abort_outputs", 64'(|{in_ready, mac_start, mac_activation, mac_weight, mac_exp_min,
                  mac_acc, res_valid, res_acc, res_exp, res_count, res_err, busy}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mac_en = 1'b1;
        repeat (2) @(negedge clk);
        check_val("post_rst_ready", 64'(in_ready), 64'(1));
        check_val("post_rst_op_q", 64'(op_q.size()), 64'(0));
        jact[0] = 16'h3C00;
        jw[0] = 4'b0001;
        jinit = $urandom;
        run_job(1, 1'b1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_int_mac_seq.md
Name: fp_int_mac_seq

Overview:
Sequencer that runs a dot product on one fp_int_mac instance. It buffers a vector of FP16 activation / INT4 weight pairs and computes the minimum activation exponent while loading. It then issues one MAC operation per element, feeding each accumulator result back into the next operation, and returns the final accumulator and exponent through a valid/ready result port.

Parameters:
ACT_WIDTH, 16, activation width (FP16: sign[15], exponent[14:10], mantissa[9:0])
W_WIDTH, 4, signed weight width
ACC_WIDTH, 32, fixed-point accumulator width
DEPTH, 16, max vector length; power of two >= 2; CNT_W = clog2(DEPTH)+1
TIMEOUT, 255, max cycles waiting for mac_done per element

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  element valid
in_ready  out  1  element accept
in_act  in  ACT_WIDTH  FP16 activation
in_weight  in  W_WIDTH  INT4 weight
in_last  in  1  last element of vector
acc_init  in  ACC_WIDTH  initial accumulator, sampled with first accepted element
mac_start  out  1  one-cycle start pulse to MAC
mac_activation  out  ACT_WIDTH  MAC operand
mac_weight  out  W_WIDTH  MAC operand
mac_exp_min  out  5  vector minimum exponent
mac_acc  out  ACC_WIDTH  accumulator into MAC
mac_acc_out  in  ACC_WIDTH  MAC fixed_point_out
mac_exp_out  in  5  MAC exp_out
mac_done  in  1  MAC completion
res_valid  out  1  result valid
res_ready  in  1  result accept
res_acc  out  ACC_WIDTH  final accumulator
res_exp  out  5  final exponent
res_count  out  CNT_W  elements processed
res_err  out  1  MAC timeout occurred
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs and internal pointers/counters 0.
- in_ready=1 only in IDLE and LOAD. Other outputs are 0 except where stated.
- States:
  - IDLE: accepting an element writes buf[0], captures acc_init and exp_min=in_act[14:10], then moves to LOAD. If that element has in_last=1, go directly to ISSUE.
  - LOAD: each accept writes buf[wr_ptr] and sets exp_min=min(exp_min, in_act[14:10]). An accept with in_last=1, or the DEPTH-th accept, registers count and moves to ISSUE next cycle. in_ready=0 from that cycle.
  - ISSUE: mac_start=1 for exactly one cycle. Drive mac_activation=buf[idx], mac_weight=buf[idx], mac_exp_min=exp_min, mac_acc=running accumulator (acc_init for idx=0). Then WAIT.
  - WAIT: hold all mac_* operands stable, mac_start=0, increment the timeout counter. On mac_done: running_acc<=mac_acc_out, res_exp<=mac_exp_out, idx++. Go to ISSUE if idx+1<count, else DONE. If the counter reaches TIMEOUT first: set res_err=1 and go to DONE with the partial accumulator.
  - DONE: res_valid=1; res_acc, res_exp, res_count, res_err held stable until res_valid&res_ready. On the next cycle go to IDLE with res_valid=0 and res_err cleared.
- mac_done outside WAIT is ignored. mac_done in the same cycle as timeout expiry counts as done, with no error.
- Per-element latency: 1 ISSUE cycle + MAC latency + 1 cycle. No pipelining; one MAC operation in flight.
- Exponent min is an unsigned compare over all elements, including zeros and subnormals.
- res_count = number of elements accepted, 1..DEPTH.
- Reset asserted in any state aborts the job. The buffer contents are don't-care.

Test Plan:
1. Elements (0x4569, 4'b0110) and (0x4AAA, 4'b0101, last), acc_init=2, MAC model with 3-cycle latency -> two single-cycle mac_start pulses; mac_exp_min=5'b10001 on both; second mac_acc equals first mac_acc_out; res_count=2; res_err=0.
2. Stream 16 elements with in_last=0 -> in_ready drops after the 16th accept; 16 start pulses; res_count=16.
3. MAC latency randomized 0..7, plus a spurious mac_done pulse in IDLE and in ISSUE -> operands stable throughout every WAIT; spurious pulses ignored; result matches the reference model.
4. MAC never asserts mac_done -> res_valid asserts TIMEOUT+2 cycles after mac_start with res_err=1 and res_acc=acc_init.
5. Hold res_ready=0 for 10 cycles in DONE -> res_* stable and in_ready=0; after the handshake, in_ready=1 next cycle and a second job runs correctly.
6. Drive rst=0 mid-WAIT -> all outputs 0 asynchronously; after release, a single-element job (0x3C00, 4'b0001, last) completes with res_count=1.
